// File: rtl/conv_pkg.sv
// Shared types and constants for the M-sequence frame controller.
//   state_t    : controller states
//   out_word_t : registered output-stream word (valid, data, frame markers)
//   tap_mask() : Fibonacci feedback tap mask for LFSR orders 2..16
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_TAIL    = 2'd2
  } state_t;

  typedef struct packed {
    logic valid;
    logic data;
    logic sof;
    logic eof;
    logic tail;
  } out_word_t;

  // Bit i set means stage i feeds the XOR; masks come from primitive polynomials.
  function automatic logic [15:0] tap_mask(input int unsigned m);
    logic [15:0] mask;
    case (m)
      2:       mask = 16'h0003;
      3:       mask = 16'h0006;
      4:       mask = 16'h000C;
      5:       mask = 16'h0014;
      6:       mask = 16'h0030;
      7:       mask = 16'h0060;
      8:       mask = 16'h00B8;
      9:       mask = 16'h0110;
      10:      mask = 16'h0240;
      11:      mask = 16'h0500;
      12:      mask = 16'h0E08;
      13:      mask = 16'h1C80;
      14:      mask = 16'h3802;
      15:      mask = 16'h6000;
      16:      mask = 16'hD008;
      default: mask = 16'h0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/mseq_frame_ctrl_if.sv
// Output bit-stream bus of the frame controller.
//   out_valid/out_ready : handshake
//   out_bit             : data bit
//   out_sof/out_eof     : first / last bit of a frame
//   out_tail            : current bit is a zero flush bit
interface mseq_frame_ctrl_if;
  logic out_valid;
  logic out_bit;
  logic out_sof;
  logic out_eof;
  logic out_tail;
  logic out_ready;

  modport master (
    output out_valid, out_bit, out_sof, out_eof, out_tail,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_bit, out_sof, out_eof, out_tail,
    output out_ready
  );
endinterface

// File: rtl/mseq_lfsr.sv
// Fibonacci shift-left LFSR of order M with load-to-all-ones.
//   clk_sig, rst_sig : clock, async active-low reset (resets to all-ones)
//   en               : advance one step
//   load             : reseed to all-ones, overrides en
//   q                : current state, q[M-1] is the output bit
module mseq_lfsr
  import conv_pkg::*;
#(
  parameter int unsigned M = 4
) (
  input  logic         clk_sig,
  input  logic         rst_sig,
  input  logic         en,
  input  logic         load,
  output logic [M-1:0] q
);

  localparam logic [15:0]  TAP_ALL = tap_mask(M);
  localparam logic [M-1:0] TAPS    = TAP_ALL[M-1:0];

  logic [M-1:0] r_q;
  logic         w_fb;

  assign w_fb = ^(r_q & TAPS);
  assign q    = r_q;

  // State register: reseed wins over advance.
  always_ff @(posedge clk_sig or negedge rst_sig) begin
    if (!rst_sig) begin
      r_q <= '1;
    end else if (load) begin
      r_q <= '1;
    end else if (en) begin
      r_q <= {r_q[M-2:0], w_fb};
    end
  end

endmodule

// File: rtl/mseq_frame_ctrl.sv
// Frame-sequencing controller for the M-sequence test source.
// Emits frames of FRAME_LEN LFSR bits followed by TAIL_LEN zero flush bits
// over a valid/ready bus; the LFSR only advances on accepted payload bits.
//   clk_sig, rst_sig : clock, async active-low reset
//   start_sig        : start a run (ignored while busy)
//   abort_sig        : stop immediately, keep frame_cnt, no done pulse
//   frame_num        : frames per run, 0 = continuous (sampled on start)
//   busy_sig         : run in progress
//   done_sig         : one-cycle pulse when a finite run completes
//   frame_cnt        : frames completed in the current run
//   bus              : output stream (master side)
module mseq_frame_ctrl
  import conv_pkg::*;
#(
  parameter int unsigned M         = 4,
  parameter int unsigned FRAME_LEN = 32,
  parameter int unsigned TAIL_LEN  = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk_sig,
  input  logic             rst_sig,
  input  logic             start_sig,
  input  logic             abort_sig,
  input  logic [CNT_W-1:0] frame_num,
  output logic             busy_sig,
  output logic             done_sig,
  output logic [CNT_W-1:0] frame_cnt,
  mseq_frame_ctrl_if.master bus
);

  localparam int unsigned LEN_MAX   = (FRAME_LEN > TAIL_LEN) ? FRAME_LEN : TAIL_LEN;
  localparam int unsigned BCNT_SPAN = (LEN_MAX > 2) ? LEN_MAX : 2;
  localparam int unsigned BCNT_W    = $clog2(BCNT_SPAN);
  localparam logic [BCNT_W-1:0] PAY_LAST  = BCNT_W'(FRAME_LEN - 1);
  localparam logic [BCNT_W-1:0] TAIL_LAST = BCNT_W'((TAIL_LEN > 0) ? TAIL_LEN - 1 : 0);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [BCNT_W-1:0] r_bit_cnt;
  logic [BCNT_W-1:0] w_bit_cnt_nxt;
  logic [CNT_W-1:0]  r_frame_cnt;
  logic [CNT_W-1:0]  w_frame_cnt_nxt;
  logic [CNT_W-1:0]  w_frame_cnt_inc;
  logic [CNT_W-1:0]  r_frame_num;
  logic [CNT_W-1:0]  w_frame_num_nxt;
  logic              r_done;
  logic              w_done_nxt;
  out_word_t         r_out;
  out_word_t         w_out_nxt;

  logic              w_xfer;
  logic              w_frame_end;
  logic              w_lfsr_en;
  logic              w_lfsr_load;
  logic [M-1:0]      w_lfsr_q;
  logic              w_lfsr_msb_nxt;
  logic              w_unused_lfsr;

  mseq_lfsr #(.M(M)) u_lfsr (
    .clk_sig (clk_sig),
    .rst_sig (rst_sig),
    .en      (w_lfsr_en),
    .load    (w_lfsr_load),
    .q       (w_lfsr_q)
  );

  // Lower LFSR stages only feed the LFSR itself.
  assign w_unused_lfsr   = ^w_lfsr_q;

  assign w_xfer          = r_out.valid & bus.out_ready;
  assign w_frame_cnt_inc = r_frame_cnt + CNT_W'(1);

  // MSB the LFSR will present after this edge, so out_bit can be a flop.
  assign w_lfsr_msb_nxt  = w_lfsr_load ? 1'b1 :
                           (w_lfsr_en ? w_lfsr_q[M-2] : w_lfsr_q[M-1]);

  // Next-state, counters and LFSR control.
  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_frame_cnt_nxt = r_frame_cnt;
    w_frame_num_nxt = r_frame_num;
    w_done_nxt      = 1'b0;
    w_lfsr_en       = 1'b0;
    w_lfsr_load     = 1'b0;
    w_frame_end     = 1'b0;

    if (abort_sig) begin
      if (r_state != ST_IDLE) begin
        w_state_nxt   = ST_IDLE;
        w_bit_cnt_nxt = '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_sig) begin
            w_state_nxt     = ST_PAYLOAD;
            w_bit_cnt_nxt   = '0;
            w_frame_cnt_nxt = '0;
            w_frame_num_nxt = frame_num;
            w_lfsr_load     = 1'b1;
          end
        end
        ST_PAYLOAD: begin
          if (w_xfer) begin
            w_lfsr_en = 1'b1;
            if (r_bit_cnt == PAY_LAST) begin
              w_bit_cnt_nxt = '0;
              if (TAIL_LEN != 0) begin
                w_state_nxt = ST_TAIL;
              end else begin
                w_frame_end = 1'b1;
              end
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + BCNT_W'(1);
            end
          end
        end
        ST_TAIL: begin
          if (w_xfer) begin
            if (r_bit_cnt == TAIL_LAST) begin
              w_bit_cnt_nxt = '0;
              w_frame_end   = 1'b1;
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + BCNT_W'(1);
            end
          end
        end
        default: begin
          w_state_nxt   = ST_IDLE;
          w_bit_cnt_nxt = '0;
        end
      endcase

      // Frame boundary: continue without a bubble unless the run is complete.
      if (w_frame_end) begin
        w_frame_cnt_nxt = w_frame_cnt_inc;
        if ((r_frame_num == '0) || (w_frame_cnt_inc != r_frame_num)) begin
          w_state_nxt = ST_PAYLOAD;
        end else begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
    end
  end

  // Output word derived from the next state; it holds while stalled since nothing changes.
  always_comb begin
    w_out_nxt       = '0;
    w_out_nxt.valid = (w_state_nxt != ST_IDLE);
    w_out_nxt.tail  = (w_state_nxt == ST_TAIL);
    w_out_nxt.sof   = (w_state_nxt == ST_PAYLOAD) && (w_bit_cnt_nxt == '0);
    w_out_nxt.eof   = ((w_state_nxt == ST_TAIL) && (w_bit_cnt_nxt == TAIL_LAST)) ||
                      ((TAIL_LEN == 0) && (w_state_nxt == ST_PAYLOAD) &&
                       (w_bit_cnt_nxt == PAY_LAST));
    w_out_nxt.data  = (w_state_nxt == ST_PAYLOAD) && w_lfsr_msb_nxt;
  end

  // State and output registers.
  always_ff @(posedge clk_sig or negedge rst_sig) begin
    if (!rst_sig) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_frame_cnt <= '0;
      r_frame_num <= '0;
      r_done      <= 1'b0;
      r_out       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_frame_num <= w_frame_num_nxt;
      r_done      <= w_done_nxt;
      r_out       <= w_out_nxt;
    end
  end

  assign bus.out_valid = r_out.valid;
  assign bus.out_bit   = r_out.data;
  assign bus.out_sof   = r_out.sof;
  assign bus.out_eof   = r_out.eof;
  assign bus.out_tail  = r_out.tail;
  assign busy_sig      = r_out.valid;
  assign done_sig      = r_done;
  assign frame_cnt     = r_frame_cnt;

endmodule

// File: tb/tb_mseq_frame_ctrl.sv
// Bench for mseq_frame_ctrl: one instance with FRAME_LEN=8/TAIL_LEN=2 and one
// with FRAME_LEN=15/TAIL_LEN=0, both M=4. Expected streams come from the
// m-sequence recurrence of x^4 + x^3 + 1 and the frame layout rules.
module tb_mseq_frame_ctrl;

  localparam int unsigned CNT_W = 16;
  localparam int FL_A = 8;
  localparam int TL_A = 2;
  localparam int FL_B = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             start_a = 1'b0, abort_a = 1'b0, busy_a, done_a;
  logic [CNT_W-1:0] fnum_a  = '0, fcnt_a;
  logic             start_b = 1'b0, abort_b = 1'b0, busy_b, done_b;
  logic [CNT_W-1:0] fnum_b  = '0, fcnt_b;

  mseq_frame_ctrl_if a_if ();
  mseq_frame_ctrl_if b_if ();

  mseq_frame_ctrl #(.M(4), .FRAME_LEN(FL_A), .TAIL_LEN(TL_A), .CNT_W(CNT_W)) u_dut_a (
    .clk_sig(clk), .rst_sig(rst_n), .start_sig(start_a), .abort_sig(abort_a),
    .frame_num(fnum_a), .busy_sig(busy_a), .done_sig(done_a), .frame_cnt(fcnt_a),
    .bus(a_if)
  );

  mseq_frame_ctrl #(.M(4), .FRAME_LEN(FL_B), .TAIL_LEN(0), .CNT_W(CNT_W)) u_dut_b (
    .clk_sig(clk), .rst_sig(rst_n), .start_sig(start_b), .abort_sig(abort_b),
    .frame_num(fnum_b), .busy_sig(busy_b), .done_sig(done_b), .frame_cnt(fcnt_b),
    .bus(b_if)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic       seq [0:127];   // reference m-sequence
  int         sidx;          // next sequence bit for the model
  logic [3:0] exp_q [$];     // expected {bit, sof, eof, tail} per transfer

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Append nfr frames of instance A to the expected stream.
  task automatic build_a(input int nfr);
    for (int f = 0; f < nfr; f++) begin
      for (int i = 0; i < FL_A; i++) begin
        exp_q.push_back({seq[sidx], (i == 0), (TL_A == 0 && i == FL_A - 1), 1'b0});
        sidx++;
      end
      for (int t = 0; t < TL_A; t++)
        exp_q.push_back({1'b0, 1'b0, (t == TL_A - 1), 1'b1});
    end
  endtask

  // Start a run on A: model is reseeded, nfr_model frames expected.
  task automatic start_a_run(input int nfr_cfg, input int nfr_model);
    sidx = 0;
    exp_q.delete();
    build_a(nfr_model);
    fnum_a  = CNT_W'(nfr_cfg);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
  endtask

  // Drive ready on A (0: high, 1: 1-0-0 pattern, 2: random) and check each
  // accepted bit; stops after max_x transfers, or when drained if max_x == 0.
  task automatic run_a(input int mode, input int max_x);
    int         nx = 0;
    int         cyc = 0;
    int         ph = 0;
    logic       stalled = 1'b0;
    logic [3:0] held = '0;
    logic [3:0] cur;
    logic [3:0] e;
    while (exp_q.size() > 0 && (max_x == 0 || nx < max_x) && cyc < 3000) begin
      case (mode)
        0:       a_if.out_ready = 1'b1;
        1:       a_if.out_ready = (ph == 0);
        default: a_if.out_ready = 1'($urandom_range(0, 1));
      endcase
      ph  = (ph == 2) ? 0 : ph + 1;
      cur = {a_if.out_bit, a_if.out_sof, a_if.out_eof, a_if.out_tail};
      chk("a_valid", a_if.out_valid, 1'b1);
      if (stalled) chk("a_hold", cur, held);
      if (a_if.out_ready) begin
        e = exp_q.pop_front();
        chk("a_xfer", cur, e);
        nx++;
        stalled = 1'b0;
      end else begin
        held    = cur;
        stalled = 1'b1;
      end
      step();
      cyc++;
    end
    if (max_x == 0) chk("a_drained", exp_q.size(), 0);
    else            chk("a_count", nx, max_x);
  endtask

  task automatic chk_idle_a(input string tag, input int fc);
    chk({tag, "_valid"}, a_if.out_valid, 1'b0);
    chk({tag, "_busy"},  busy_a, 1'b0);
    chk({tag, "_fcnt"},  fcnt_a, fc);
  endtask

  initial begin
    int nfr;
    logic [3:0] e;

    // Output recurrence of x^4 + x^3 + 1 seeded with all-ones.
    for (int n = 0; n < 128; n++)
      seq[n] = (n < 4) ? 1'b1 : (seq[n-4] ^ seq[n-3]);

    a_if.out_ready = 1'b0;
    b_if.out_ready = 1'b0;

    // Reset state.
    step();
    step();
    chk("rst_valid", a_if.out_valid, 1'b0);
    chk("rst_bit",   a_if.out_bit,   1'b0);
    chk("rst_sof",   a_if.out_sof,   1'b0);
    chk("rst_eof",   a_if.out_eof,   1'b0);
    chk("rst_tail",  a_if.out_tail,  1'b0);
    chk("rst_busy",  busy_a,         1'b0);
    chk("rst_done",  done_a,         1'b0);
    chk("rst_fcnt",  fcnt_a,         0);
    chk("rst_b_valid", b_if.out_valid, 1'b0);
    #2 rst_n = 1'b1;
    step();

    // Two frames at full rate; done one cycle after the last bit.
    start_a_run(2, 2);
    chk("t1_sof0", a_if.out_sof, 1'b1);
    run_a(0, 0);
    chk("t1_done", done_a, 1'b1);
    chk_idle_a("t1", 2);
    step();
    chk("t1_done_pulse", done_a, 1'b0);

    // Same stream with 1-0-0 backpressure.
    start_a_run(2, 2);
    run_a(1, 0);
    chk("t2_done", done_a, 1'b1);
    chk_idle_a("t2", 2);
    step();

    // Random frame count and random backpressure, a few runs.
    for (int r = 0; r < 3; r++) begin
      nfr = int'($urandom_range(1, 3));
      start_a_run(nfr, nfr);
      run_a(2, 0);
      chk("t3_done", done_a, 1'b1);
      chk_idle_a("t3", nfr);
      step();
    end

    // Abort with a pending bit after 5 accepted bits of frame 1.
    start_a_run(3, 3);
    run_a(0, FL_A + TL_A + 5);
    a_if.out_ready = 1'b0;
    chk("t4_pending", a_if.out_valid, 1'b1);
    step();
    abort_a = 1'b1;
    step();
    abort_a = 1'b0;
    chk("t4_done", done_a, 1'b0);
    chk_idle_a("t4", 1);
    step();
    chk("t4_done_late", done_a, 1'b0);
    chk_idle_a("t4_late", 1);

    // Restart after abort reseeds to all-ones.
    start_a_run(1, 1);
    run_a(0, 0);
    chk("t4r_done", done_a, 1'b1);
    step();

    // Start (with a different frame_num) while busy has no effect.
    start_a_run(1, 1);
    run_a(0, 3);
    start_a = 1'b1;
    fnum_a  = CNT_W'(5);
    run_a(0, 1);
    start_a = 1'b0;
    run_a(0, 0);
    chk("t5_done", done_a, 1'b1);
    chk_idle_a("t5", 1);
    step();

    // Start and abort together in IDLE: stays idle.
    start_a = 1'b1;
    abort_a = 1'b1;
    step();
    start_a = 1'b0;
    abort_a = 1'b0;
    chk_idle_a("t6", 1);
    step();
    chk_idle_a("t6_late", 1);

    // Reset mid-TAIL: outputs clear without waiting for a clock edge.
    start_a_run(2, 2);
    run_a(0, FL_A + TL_A + FL_A + 1);
    chk("t7_in_tail", a_if.out_tail, 1'b1);
    chk("t7_fcnt_pre", fcnt_a, 1);
    rst_n = 1'b0;
    #1;
    chk("t7_valid", a_if.out_valid, 1'b0);
    chk("t7_bit",   a_if.out_bit,   1'b0);
    chk("t7_sof",   a_if.out_sof,   1'b0);
    chk("t7_eof",   a_if.out_eof,   1'b0);
    chk("t7_tail",  a_if.out_tail,  1'b0);
    chk("t7_busy",  busy_a,         1'b0);
    chk("t7_done",  done_a,         1'b0);
    chk("t7_fcnt",  fcnt_a,         0);
    #2 rst_n = 1'b1;
    step();
    start_a_run(1, 1);
    run_a(2, 0);
    chk("t7r_done", done_a, 1'b1);
    step();

    // Continuous 15-bit frames with no tail on instance B.
    b_if.out_ready = 1'b1;
    fnum_b  = '0;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    for (int n = 0; n < 3 * FL_B; n++) begin
      e = {seq[n % FL_B], (n % FL_B == 0), (n % FL_B == FL_B - 1), 1'b0};
      chk("b_valid", b_if.out_valid, 1'b1);
      chk("b_word", {b_if.out_bit, b_if.out_sof, b_if.out_eof, b_if.out_tail}, e);
      chk("b_fcnt", fcnt_b, n / FL_B);
      chk("b_done", done_b, 1'b0);
      step();
    end
    chk("b_fcnt_end", fcnt_b, 3);
    abort_b = 1'b1;
    step();
    abort_b = 1'b0;
    chk("b_abort_valid", b_if.out_valid, 1'b0);
    chk("b_abort_done",  done_b, 1'b0);
    chk("b_abort_busy",  busy_b, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
